decoder_4_to_16: RTL and testbench



---
 rtl/decoder_pkg.sv | 12 +
 rtl/decoder_2_to_4.sv | 23 ++
 rtl/decoder_4_to_16.sv | 42 ++++
 tb/tb_decoder_4_to_16.sv | 123 ++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared widths and constants for the 4-to-16 select decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package decoder_pkg;

  localparam int SEL_W = 4;
  localparam int OUT_W = 2 ** SEL_W;

  // All-zero decode word: reset value and the disabled-decode result.
  localparam logic [OUT_W-1:0] ONE_HOT_ZERO = '0;

endpackage : decoder_pkg

// File: rtl/decoder_2_to_4.sv
// Gate-level 2-to-4 one-hot decoder cell with active-high enable.
// Latency: combinational, no clock. Ports: en (1), s (2) select, y (4) one-hot.
// Backpressure: none; y follows en and s directly.
module decoder_2_to_4 (
  input  logic       en,
  input  logic [1:0] s,
  output logic [3:0] y
);

  logic s0_n;
  logic s1_n;

  // Inverted select literals; true literals are taken straight from s.
  not u_not_s0 (s0_n, s[0]);
  not u_not_s1 (s1_n, s[1]);

  // Each output is one minterm of s, qualified by en.
  and u_and_y0 (y[0], en, s1_n, s0_n);
  and u_and_y1 (y[1], en, s1_n, s[0]);
  and u_and_y2 (y[2], en, s[1], s0_n);
  and u_and_y3 (y[3], en, s[1], s[0]);

endmodule : decoder_2_to_4

// File: rtl/decoder_4_to_16.sv
// Registered 4-to-16 one-hot decoder built from five 2-to-4 gate-level cells.
// Latency: 1 clk (out reflects a/ena at the previous rising edge). Ports: clk, rst (sync, active-high), ena, a (4), out (16).
// Backpressure: none; accepts a new select every cycle.
module decoder_4_to_16
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] out
);

  logic [3:0]       g;
  logic [OUT_W-1:0] nxt;

  // First level: a[3:2] picks which group of four outputs is enabled.
  decoder_2_to_4 u_dec_hi (
    .en (ena),
    .s  (a[3:2]),
    .y  (g)
  );

  // Second level: each enabled group decodes a[1:0] into its four outputs.
  for (genvar j = 0; j < 4; j++) begin : g_lo
    decoder_2_to_4 u_dec_lo (
      .en (g[j]),
      .s  (a[1:0]),
      .y  (nxt[4*j+3:4*j])
    );
  end

  // Output register keeps out glitch-free; reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= ONE_HOT_ZERO;
    end else begin
      out <= nxt;
    end
  end

endmodule : decoder_4_to_16

// File: tb/tb_decoder_4_to_16.sv
// Directed self-checking bench for decoder_4_to_16 and the decoder_2_to_4 cell.
// Latency: checks out 1 clk after each applied vector.
// Backpressure: n/a.
module tb_decoder_4_to_16;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  a;
  logic [15:0] dout;

  logic        cell_en;
  logic [1:0]  cell_s;
  logic [3:0]  cell_y;

  int checks;
  int errors;

  decoder_4_to_16 u_dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .a   (a),
    .out (dout)
  );

  decoder_2_to_4 u_cell (
    .en (cell_en),
    .s  (cell_s),
    .y  (cell_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one vector, clock it in, then settle just after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] av);
    rst = r;
    ena = e;
    a   = av;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_v;
    logic [3:0]  exp_y;
    checks  = 0;
    errors  = 0;
    cell_en = 1'b0;
    cell_s  = 2'd0;

    // Reset held with ena high; then release.
    step(1'b1, 1'b1, 4'd5);
    chk("reset_edge1", dout, 16'h0000);
    step(1'b1, 1'b1, 4'd5);
    chk("reset_edge2", dout, 16'h0000);
    step(1'b0, 1'b1, 4'd5);
    chk("reset_release", dout, 16'h0020);

    // Enabled sweep over every select value.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(i));
      exp_v = 16'h0001 << i;
      chk("sweep", dout, exp_v);
      chk("sweep_onehot", {15'd0, $onehot(dout)}, 16'h0001);
    end

    // Disabled sweep: nothing should ever decode.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'(i));
      chk("ena_off", dout, 16'h0000);
    end
    step(1'b0, 1'b1, 4'd9);
    chk("ena_rise", dout, 16'h0200);

    // Mid-cycle select change must not reach out until the next edge.
    step(1'b0, 1'b1, 4'd3);
    chk("hold_a3", dout, 16'h0008);
    #3 a = 4'd12;
    #2 chk("hold_midcycle", dout, 16'h0008);
    @(posedge clk);
    #1;
    chk("hold_a12", dout, 16'h1000);

    // Reset pulse in the middle of traffic.
    step(1'b0, 1'b1, 4'd7);
    chk("mid_a7", dout, 16'h0080);
    step(1'b1, 1'b1, 4'd7);
    chk("mid_reset", dout, 16'h0000);
    step(1'b0, 1'b1, 4'd8);
    chk("mid_a8", dout, 16'h0100);

    // ena falling with a held steady.
    step(1'b0, 1'b1, 4'd4);
    chk("fall_a4", dout, 16'h0010);
    step(1'b0, 1'b0, 4'd4);
    chk("fall_off", dout, 16'h0000);

    // Standalone 2-to-4 cell, all eight input combinations.
    for (int e = 0; e < 2; e++) begin
      for (int s = 0; s < 4; s++) begin
        cell_en = 1'(e);
        cell_s  = 2'(s);
        #1;
        exp_y = (e == 1) ? (4'b0001 << s) : 4'b0000;
        chk("cell", {12'd0, cell_y}, {12'd0, exp_y});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_4_to_16
